butterfly_pipe: RTL and testbench

//  Parametrised, fully pipelined radix-2 complex butterfly for the streaming FFT datapath.

---
 rtl/fft_pkg.sv | 39 +++
 rtl/cmul_pipe.sv | 50 +++++
 rtl/butterfly_pipe.sv | 198 +++++++++++++++++++
 tb/tb_butterfly_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and the W+1 -> W narrowing helpers for the radix-2 butterfly datapath.
package fft_pkg;

    localparam int LAT = 4;

    localparam logic MODE_DIT = 1'b0;
    localparam logic MODE_DIF = 1'b1;

    // Widest component the narrowing helpers handle; callers sign-extend into wide_t.
    localparam int NARROW_MAX_W = 32;
    typedef logic signed [NARROW_MAX_W:0] wide_t;

    function automatic logic narrow_ovf(input wide_t x, input int w, input logic scale);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        return !scale && ((x > hi) || (x < lo));
    endfunction

    // scale: floor /2, which always fits. Otherwise keep the low w bits, or clamp when sat_en.
    function automatic wide_t sat_narrow(input wide_t x, input int w, input logic scale,
                                         input logic sat_en);
        wide_t hi;
        wide_t lo;
        wide_t r;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        if (scale) begin
            r = x >>> 1;
        end else if (sat_en && narrow_ovf(x, w, 1'b0)) begin
            r = (x < 0) ? lo : hi;
        end else begin
            r = (x <<< (NARROW_MAX_W + 1 - w)) >>> (NARROW_MAX_W + 1 - w);
        end
        return r;
    endfunction

endpackage

// File: rtl/cmul_pipe.sv
// Two-stage complex multiplier: first stage registers the four partial products, second stage
// combines them, rounds half-up and keeps the Q1.(W-1) result. Advances only when i_en.
module cmul_pipe #(
    parameter int W  = 16,
    parameter int TW = 16
) (
    input  logic                 clk,
    input  logic                 i_en,
    input  logic signed [W-1:0]  i_br,
    input  logic signed [W-1:0]  i_bc,
    input  logic signed [TW-1:0] i_twr,
    input  logic signed [TW-1:0] i_twc,
    output logic signed [W-1:0]  o_re,
    output logic signed [W-1:0]  o_im
);

    localparam int PW = W + TW;
    localparam logic signed [PW:0] RND = (PW + 1)'(1) <<< (TW - 2);

    logic signed [PW-1:0] r_rr_p2, r_ii_p2, r_ri_p2, r_ir_p2;
    logic signed [PW:0]   w_re, w_im;
    logic signed [W-1:0]  r_re_p3, r_im_p3;

    // S2: partial products
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rr_p2 <= PW'(i_br) * PW'(i_twr);
            r_ii_p2 <= PW'(i_bc) * PW'(i_twc);
            r_ri_p2 <= PW'(i_br) * PW'(i_twc);
            r_ir_p2 <= PW'(i_bc) * PW'(i_twr);
        end
    end

    // S3: combine, round half-up, take bits [W+TW-2:TW-1]
    always_comb begin
        w_re = (PW + 1)'(r_rr_p2) - (PW + 1)'(r_ii_p2) + RND;
        w_im = (PW + 1)'(r_ri_p2) + (PW + 1)'(r_ir_p2) + RND;
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_re_p3 <= W'(w_re >>> (TW - 1));
            r_im_p3 <= W'(w_im >>> (TW - 1));
        end
    end

    assign o_re = r_re_p3;
    assign o_im = r_im_p3;

endmodule

// File: rtl/butterfly_pipe.sv
// Fully pipelined radix-2 complex butterfly, DIT or DIF chosen per beat, 4-cycle latency, global stall.
// Define BFLY_SAT_EN to clamp overflowing components and flag them on o_ovf; otherwise results wrap.
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int W     = 16,
    parameter int TW    = 16,
    parameter int TAG_W = 8,
    parameter int SCALE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic                 i_mode,
    input  logic signed [W-1:0]  i_ra,
    input  logic signed [W-1:0]  i_ca,
    input  logic signed [W-1:0]  i_rb,
    input  logic signed [W-1:0]  i_cb,
    input  logic signed [TW-1:0] i_tw_r,
    input  logic signed [TW-1:0] i_tw_c,
    input  logic [TAG_W-1:0]     i_tag,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic signed [W-1:0]  o_ra,
    output logic signed [W-1:0]  o_ca,
    output logic signed [W-1:0]  o_rb,
    output logic signed [W-1:0]  o_cb,
    output logic [TAG_W-1:0]     o_tag,
    output logic                 o_ovf
);

`ifdef BFLY_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif
    localparam logic SCL = (SCALE != 0);

    logic w_en;
    logic signed [W:0]    w_sr, w_sc, w_dr, w_dc;
    logic signed [W-1:0]  w_sr_n, w_sc_n, w_dr_n, w_dc_n;
    logic signed [W-1:0]  r_ar_p1, r_ac_p1, r_br_p1, r_bc_p1;
    logic signed [TW-1:0] r_twr_p1, r_twc_p1;
    logic signed [W-1:0]  r_ar_p2, r_ac_p2, r_ar_p3, r_ac_p3;
    logic [TAG_W-1:0]     r_tag_p1, r_tag_p2, r_tag_p3, r_tag_p4;
    logic                 r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4;
    logic                 r_mode_p1, r_mode_p2, r_mode_p3;
    logic signed [W-1:0]  w_pr_p3, w_pi_p3;
    logic signed [W:0]    w_xr, w_xc, w_yr, w_yc;
    logic signed [W-1:0]  w_ra_s4, w_ca_s4, w_rb_s4, w_cb_s4;
    logic signed [W-1:0]  r_ra_p4, r_ca_p4, r_rb_p4, r_cb_p4;

    // The whole pipe freezes only while a finished beat waits on the consumer.
    assign w_en    = ~(r_vld_p4 & ~o_ready);
    assign i_ready = w_en;

    // S1: DIF pre-add/subtract, narrowed back to W
    always_comb begin
        w_sr   = (W + 1)'(i_ra) + (W + 1)'(i_rb);
        w_sc   = (W + 1)'(i_ca) + (W + 1)'(i_cb);
        w_dr   = (W + 1)'(i_ra) - (W + 1)'(i_rb);
        w_dc   = (W + 1)'(i_ca) - (W + 1)'(i_cb);
        w_sr_n = W'(sat_narrow(wide_t'(w_sr), W, SCL, SAT_EN));
        w_sc_n = W'(sat_narrow(wide_t'(w_sc), W, SCL, SAT_EN));
        w_dr_n = W'(sat_narrow(wide_t'(w_dr), W, SCL, SAT_EN));
        w_dc_n = W'(sat_narrow(wide_t'(w_dc), W, SCL, SAT_EN));
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_ar_p1  <= (i_mode == MODE_DIF) ? w_sr_n : i_ra;
            r_ac_p1  <= (i_mode == MODE_DIF) ? w_sc_n : i_ca;
            r_br_p1  <= (i_mode == MODE_DIF) ? w_dr_n : i_rb;
            r_bc_p1  <= (i_mode == MODE_DIF) ? w_dc_n : i_cb;
            r_twr_p1 <= i_tw_r;
            r_twc_p1 <= i_tw_c;
            r_tag_p1 <= i_tag;
            r_ar_p2  <= r_ar_p1;
            r_ac_p2  <= r_ac_p1;
            r_tag_p2 <= r_tag_p1;
            r_ar_p3  <= r_ar_p2;
            r_ac_p3  <= r_ac_p2;
            r_tag_p3 <= r_tag_p2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_vld_p3  <= 1'b0;
            r_mode_p1 <= MODE_DIT;
            r_mode_p2 <= MODE_DIT;
            r_mode_p3 <= MODE_DIT;
        end else if (w_en) begin
            r_vld_p1  <= i_valid;
            r_vld_p2  <= r_vld_p1;
            r_vld_p3  <= r_vld_p2;
            r_mode_p1 <= i_mode;
            r_mode_p2 <= r_mode_p1;
            r_mode_p3 <= r_mode_p2;
        end
    end

    // S2/S3: B*W for DIT, (A-B)*W for DIF
    cmul_pipe #(
        .W  (W),
        .TW (TW)
    ) u_cmul (
        .clk   (clk),
        .i_en  (w_en),
        .i_br  (r_br_p1),
        .i_bc  (r_bc_p1),
        .i_twr (r_twr_p1),
        .i_twc (r_twc_p1),
        .o_re  (w_pr_p3),
        .o_im  (w_pi_p3)
    );

    // S4: DIT post-add/subtract; DIF results pass straight to the output register
    always_comb begin
        w_xr = (W + 1)'(r_ar_p3) + (W + 1)'(w_pr_p3);
        w_xc = (W + 1)'(r_ac_p3) + (W + 1)'(w_pi_p3);
        w_yr = (W + 1)'(r_ar_p3) - (W + 1)'(w_pr_p3);
        w_yc = (W + 1)'(r_ac_p3) - (W + 1)'(w_pi_p3);
        if (r_mode_p3 == MODE_DIF) begin
            w_ra_s4 = r_ar_p3;
            w_ca_s4 = r_ac_p3;
            w_rb_s4 = w_pr_p3;
            w_cb_s4 = w_pi_p3;
        end else begin
            w_ra_s4 = W'(sat_narrow(wide_t'(w_xr), W, SCL, SAT_EN));
            w_ca_s4 = W'(sat_narrow(wide_t'(w_xc), W, SCL, SAT_EN));
            w_rb_s4 = W'(sat_narrow(wide_t'(w_yr), W, SCL, SAT_EN));
            w_cb_s4 = W'(sat_narrow(wide_t'(w_yc), W, SCL, SAT_EN));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_p4 <= 1'b0;
            r_ra_p4  <= '0;
            r_ca_p4  <= '0;
            r_rb_p4  <= '0;
            r_cb_p4  <= '0;
            r_tag_p4 <= '0;
        end else if (w_en) begin
            r_vld_p4 <= r_vld_p3;
            r_ra_p4  <= w_ra_s4;
            r_ca_p4  <= w_ca_s4;
            r_rb_p4  <= w_rb_s4;
            r_cb_p4  <= w_cb_s4;
            r_tag_p4 <= r_tag_p3;
        end
    end

    assign o_valid = r_vld_p4;
    assign o_ra    = r_ra_p4;
    assign o_ca    = r_ca_p4;
    assign o_rb    = r_rb_p4;
    assign o_cb    = r_cb_p4;
    assign o_tag   = r_tag_p4;

`ifdef BFLY_SAT_EN
    logic w_ovf_s1, w_ovf_s4;
    logic r_ovf_p1, r_ovf_p2, r_ovf_p3, r_ovf_p4;

    // A beat is flagged if any component clamped at either narrowing point.
    always_comb begin
        w_ovf_s1 = (i_mode == MODE_DIF) &
                   (narrow_ovf(wide_t'(w_sr), W, SCL) | narrow_ovf(wide_t'(w_sc), W, SCL) |
                    narrow_ovf(wide_t'(w_dr), W, SCL) | narrow_ovf(wide_t'(w_dc), W, SCL));
        w_ovf_s4 = (r_mode_p3 == MODE_DIT) &
                   (narrow_ovf(wide_t'(w_xr), W, SCL) | narrow_ovf(wide_t'(w_xc), W, SCL) |
                    narrow_ovf(wide_t'(w_yr), W, SCL) | narrow_ovf(wide_t'(w_yc), W, SCL));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf_p1 <= 1'b0;
            r_ovf_p2 <= 1'b0;
            r_ovf_p3 <= 1'b0;
            r_ovf_p4 <= 1'b0;
        end else if (w_en) begin
            r_ovf_p1 <= w_ovf_s1;
            r_ovf_p2 <= r_ovf_p1;
            r_ovf_p3 <= r_ovf_p2;
            r_ovf_p4 <= r_ovf_p3 | w_ovf_s4;
        end
    end

    assign o_ovf = r_ovf_p4;
`else
    assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed bench for butterfly_pipe: one unscaled and one SCALE=1 instance share the input stream.
module tb_butterfly_pipe;
    import fft_pkg::*;

    localparam int W     = 16;
    localparam int TW    = 16;
    localparam int TAG_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, i_valid, i_mode, o_ready;
    logic [W-1:0]     i_ra, i_ca, i_rb, i_cb;
    logic [TW-1:0]    i_tw_r, i_tw_c;
    logic [TAG_W-1:0] i_tag;
    logic             i_ready, o_valid, o_ovf;
    logic [W-1:0]     o_ra, o_ca, o_rb, o_cb;
    logic [TAG_W-1:0] o_tag;
    logic             i_ready_s, o_valid_s, o_ovf_s;
    logic [W-1:0]     o_ra_s, o_ca_s, o_rb_s, o_cb_s;
    logic [TAG_W-1:0] o_tag_s;

    butterfly_pipe #(.W(W), .TW(TW), .TAG_W(TAG_W), .SCALE(0)) u_dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_mode(i_mode),
        .i_ra(i_ra), .i_ca(i_ca), .i_rb(i_rb), .i_cb(i_cb), .i_tw_r(i_tw_r), .i_tw_c(i_tw_c),
        .i_tag(i_tag), .o_valid(o_valid), .o_ready(o_ready), .o_ra(o_ra), .o_ca(o_ca),
        .o_rb(o_rb), .o_cb(o_cb), .o_tag(o_tag), .o_ovf(o_ovf)
    );

    butterfly_pipe #(.W(W), .TW(TW), .TAG_W(TAG_W), .SCALE(1)) u_dut_s (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready_s), .i_mode(i_mode),
        .i_ra(i_ra), .i_ca(i_ca), .i_rb(i_rb), .i_cb(i_cb), .i_tw_r(i_tw_r), .i_tw_c(i_tw_c),
        .i_tag(i_tag), .o_valid(o_valid_s), .o_ready(o_ready), .o_ra(o_ra_s), .o_ca(o_ca_s),
        .o_rb(o_rb_s), .o_cb(o_cb_s), .o_tag(o_tag_s), .o_ovf(o_ovf_s)
    );

    typedef struct packed {
        logic        mode;
        logic [15:0] ra, ca, rb, cb, twr, twc;
        logic [15:0] ar, ac, br, bc;
        logic        ovf;
    } vec_t;

    vec_t vecs [5];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_vec(input int v, input logic [TAG_W-1:0] tag);
        assert (vecs[v].twr != 16'h8000 && vecs[v].twc != 16'h8000)
            else $error("illegal twiddle value in vector %0d", v);
        i_mode = vecs[v].mode;
        i_ra   = vecs[v].ra;
        i_ca   = vecs[v].ca;
        i_rb   = vecs[v].rb;
        i_cb   = vecs[v].cb;
        i_tw_r = vecs[v].twr;
        i_tw_c = vecs[v].twc;
        i_tag  = tag;
    endtask

    // One isolated beat; results must appear exactly LAT cycles after the accepting cycle.
    task automatic run_vec(input int v, input logic [TAG_W-1:0] tag);
        @(posedge clk); #1;
        drive_vec(v, tag);
        i_valid = 1'b1;
        check_val("accept_ready", i_ready, 1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (LAT - 2) @(posedge clk);
        #1 check_val("early_valid", o_valid, 0);
        @(posedge clk); #1;
        check_val("lat_valid", o_valid, 1);
        check_val("res_ra", o_ra, vecs[v].ar);
        check_val("res_ca", o_ca, vecs[v].ac);
        check_val("res_rb", o_rb, vecs[v].br);
        check_val("res_cb", o_cb, vecs[v].bc);
        check_val("res_tag", o_tag, tag);
        check_val("res_ovf", o_ovf, vecs[v].ovf);
    endtask

    int               k, j, nv;
    logic             stalled_prev, accept;
    logic [W-1:0]     snap_ra, snap_cb;
    logic [TAG_W-1:0] snap_tag;

    initial begin
        vecs[0] = '{1'b0, 16'h1000, 16'h0200, 16'h0800, 16'hFC00, 16'h7FFF, 16'h0000,
                    16'h1800, 16'hFE00, 16'h0800, 16'h0600, 1'b0};
        vecs[1] = '{1'b1, 16'h1000, 16'h0000, 16'h0800, 16'h0000, 16'h0000, 16'h7FFF,
                    16'h1800, 16'h0000, 16'h0000, 16'h0800, 1'b0};
        vecs[2] = '{1'b0, 16'h1000, 16'h0200, 16'h0800, 16'hFC00, 16'h0000, 16'h7FFF,
                    16'h1400, 16'h0A00, 16'h0C00, 16'hFA00, 1'b0};
        vecs[3] = '{1'b1, 16'h1000, 16'h0000, 16'h0800, 16'h0000, 16'h7FFF, 16'h0000,
                    16'h1800, 16'h0000, 16'h0800, 16'h0000, 1'b0};
`ifdef BFLY_SAT_EN
        vecs[4] = '{1'b0, 16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000,
                    16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 1'b1};
`else
        vecs[4] = '{1'b0, 16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000,
                    16'hDFFF, 16'h0000, 16'h0001, 16'h0000, 1'b0};
`endif

        rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
        drive_vec(0, '0);
        #1 rst = 1'b0;
        #1;
        check_val("rst_valid", o_valid, 0);
        check_val("rst_ra", o_ra, 0);
        check_val("rst_tag", o_tag, 0);
        check_val("rst_ovf", o_ovf, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_val("rst_ready", i_ready, 1);

        // Reset with three beats in flight.
        @(posedge clk); #1;
        for (int b = 1; b <= 3; b++) begin
            drive_vec(0, TAG_W'(b));
            i_valid = 1'b1;
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        @(posedge clk); #1;
        check_val("flight_valid", o_valid, 1);
        check_val("flight_tag", o_tag, 1);
        rst = 1'b0;
        #1;
        check_val("mid_rst_valid", o_valid, 0);
        check_val("mid_rst_ra", o_ra, 0);
        check_val("mid_rst_tag", o_tag, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_val("post_rst_ready", i_ready, 1);
        check_val("post_rst_ready_s", i_ready_s, 1);
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (o_valid) nv++;
        end
        check_val("stale_beats", nv, 0);

        run_vec(0, 8'h21);
        run_vec(2, 8'h32);
        run_vec(1, 8'h43);
        check_val("s_dif_valid", o_valid_s, 1);
        check_val("s_dif_ra", o_ra_s, 16'h0C00);
        check_val("s_dif_ca", o_ca_s, 16'h0000);
        check_val("s_dif_rb", o_rb_s, 16'h0000);
        check_val("s_dif_cb", o_cb_s, 16'h0400);
        check_val("s_dif_tag", o_tag_s, 8'h43);
        run_vec(4, 8'h54);
        check_val("s_ovf_ra", o_ra_s, 16'h6FFF);
        check_val("s_ovf_flag", o_ovf_s, 0);

        // Streaming with alternating modes and a 3-cycle downstream stall.
        k = 0; j = 0; stalled_prev = 1'b0;
        @(posedge clk); #1;
        drive_vec(0, 8'hA0);
        i_valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            o_ready = !(cyc >= 6 && cyc <= 8);
            #1;
            if (stalled_prev) begin
                check_val("hold_ra", o_ra, snap_ra);
                check_val("hold_cb", o_cb, snap_cb);
                check_val("hold_tag", o_tag, snap_tag);
            end
            if (o_valid && !o_ready) check_val("stall_ready", i_ready, 0);
            if (o_valid && o_ready) begin
                if (j < 8) begin
                    check_val("strm_tag", o_tag, 8'hA0 + TAG_W'(j));
                    check_val("strm_ra", o_ra, vecs[j % 4].ar);
                    check_val("strm_ca", o_ca, vecs[j % 4].ac);
                    check_val("strm_rb", o_rb, vecs[j % 4].br);
                    check_val("strm_cb", o_cb, vecs[j % 4].bc);
                    check_val("strm_ovf", o_ovf, 0);
                end else begin
                    check_val("extra_beat", j, 7);
                end
                j++;
            end
            stalled_prev = o_valid && !o_ready;
            snap_ra  = o_ra;
            snap_cb  = o_cb;
            snap_tag = o_tag;
            accept   = i_valid && i_ready;
            @(posedge clk); #1;
            if (accept) begin
                k++;
                if (k < 8) drive_vec(k % 4, 8'hA0 + TAG_W'(k));
                else i_valid = 1'b0;
            end
        end
        check_val("strm_count", j, 8);
        check_val("strm_sent", k, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
